sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
Downstream consumer of the LFSR stochastic bitstream generator. It sequences the generator and counts the ones in one full observation window, recovering the binary value the stream encodes. On request it does three things: loads a seed into the generator, runs the generator for exactly LEN cycles while accumulating `x_in`, then presents the count on a valid/ready output. It closes the compress/decompress loop in the decompressor path, for round-trip checking and for SC result readback.

Parameters:
- N, 7: generator bit width. Must match the generator instance.
- LEN, 2**N-1: window length in cycles. The default equals the maximal LFSR period, so every non-zero LFSR state is visited exactly once. Legal range 1..2**N.
- CW, N+1: count/result width. Holds values up to 2**N.

Ports:
- clk  in  1  clock.
- rst_n  in  1  active-low reset, asynchronous assert; one clock, reset is asynchronous and active-low.
- start  in  1  request a conversion. Accepted only in IDLE.
- seed_in  in  N  seed for this conversion. Captured when start is accepted.
- clear  in  1  synchronous abort. Returns to IDLE from any state.
- gen_load  out  1  drives the generator's `load`.
- gen_enable  out  1  drives the generator's `enable`.
- gen_seed  out  N  drives the generator's `seed`. Holds the captured seed.
- x_in  in  1  the generator's `x_out` (combinational from the current LFSR state).
- result  out  CW  ones count of the last window.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. The state register is reset asynchronously to IDLE.
- Reset values: `result`=0, `result_valid`=0, `gen_load`=0, `gen_enable`=0, `gen_seed`=0, `busy`=0. The internal counters are 0.
- IDLE:
  - `start`=1 captures `seed_in` into `seed_q` and moves to LOAD.
  - Otherwise the FSM stays in IDLE.
- LOAD (exactly 1 cycle):
  - `gen_load`=1 and `gen_enable`=0.
  - `ones_cnt` and `cyc_cnt` are cleared.
  - Next state is RUN.
- RUN:
  - `gen_enable`=1 on every cycle.
  - Each cycle samples `x_in`, which reflects the LFSR state before that cycle's shift: `ones_cnt` += `x_in`, `cyc_cnt` += 1.
  - On the cycle where `cyc_cnt`==LEN-1, that final sample is included, `result` <= final count, and the FSM moves to DONE.
  - There are exactly LEN RUN cycles.
- DONE:
  - `result_valid`=1 and `gen_enable`=0.
  - `result` is held stable until `result_ready`=1.
  - The handshake completes on the cycle where `result_valid` && `result_ready` are both high; the next state is IDLE and `result_valid` drops.
  - `result_valid` must not drop without `result_ready`.
  - `result` keeps its value in IDLE after the handshake.
- Latency: with `start` high at cycle t in IDLE, LOAD is at t+1, RUN spans t+2 .. t+LEN+1, and `result_valid` rises at t+LEN+2. For the default (LEN=127), that is t+129.
- `gen_load` and `gen_enable` are decoded from the state register (registered FSM outputs). They are never both high.
- `start` outside IDLE is ignored (no queuing). `start` in the same cycle as the DONE handshake is ignored as well; a new start must be presented in IDLE.
- `clear`:
  - Highest priority after reset. From any state it goes to IDLE next cycle.
  - It clears `result_valid`, `ones_cnt` and `cyc_cnt`.
  - It leaves `result` and `seed_q` unchanged.
  - Asserting `clear` and `start` together in IDLE: `clear` wins and the FSM stays in IDLE.
- Async reset mid-RUN: the FSM goes to IDLE immediately and all outputs take their reset values. The generator is left un-enabled; its state is irrelevant because the next conversion reloads the seed.
- Arithmetic:
  - `ones_cnt` and `result` are CW bits wide and cannot overflow, since LEN <= 2**N < 2**CW.
  - `cyc_cnt` is ceil(log2(LEN+1)) bits wide.
- Expected value (LEN=2**N-1, nonzero seed): `result` = max(k-1, 0), independent of seed. The all-zero LFSR state is never visited, so only states 1..k-1 satisfy `lfsr < k`.

Decomposition:
- Shared package `sc_pkg` holds:
  - the FSM state enum (IDLE/LOAD/RUN/DONE);
  - localparams for the default N and LEN;
  - a width function clog2 used for `cyc_cnt`.
- One natural sub-module: `sc_ones_counter`, which implements `ones_cnt` and `cyc_cnt` with clear/enable and a terminal-count flag. The top level instantiates it beside the FSM.
- The bench top wires `sc_stream_decoder` to the generator; the generator is not instantiated inside this block.

Test Plan:
- k=64, seed=7'h01, start pulse, `result_ready`=1 -> `result_valid` rises exactly 129 cycles after start, `result`=63; `gen_load` is high for exactly 1 cycle and `gen_enable` for exactly 127 cycles.
- Boundaries: k=0 -> `result`=0; k=1 -> 0; k=127 -> 126. Repeat each with seed=7'h5A and seed=7'h00 (generator substitutes all-ones) -> results are identical.
- Backpressure: k=100, `result_ready` held 0 for 20 cycles after `result_valid` -> `result`=99 is held stable and `valid` stays high; the `ready` pulse moves the FSM to IDLE next cycle and `busy` drops.
- start pulses during RUN and DONE -> ignored; the result and cycle timing match the first conversion; no second conversion begins.
- `clear` at RUN cycle 50 -> IDLE next cycle, `gen_enable`=0, `result_valid` never rises. A following start with k=10 -> `result`=9.
- Async `rst_n` low mid-RUN, released 3 cycles later -> all outputs at reset values while low; a subsequent full conversion with k=64 -> 63.

Source files
------------

// File: rtl/sc_stream_decoder_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEF_N   = 7;
    localparam int DEF_LEN = 2**DEF_N - 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Generator control and result handshake bundle of the stream decoder.
interface sc_stream_decoder_if #(
    parameter int N  = 7,
    parameter int CW = N + 1
) ();
    logic          gen_load;
    logic          gen_enable;
    logic [N-1:0]  gen_seed;
    logic          x_in;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    modport master (
        output gen_load, gen_enable, gen_seed, result, result_valid,
        input  x_in, result_ready
    );

    modport slave (
        input  gen_load, gen_enable, gen_seed, result, result_valid,
        output x_in, result_ready
    );
endinterface

// File: rtl/sc_stream_decoder_ones_counter.sv
// Window accumulator: counts ones and elapsed cycles, flags the last window cycle.
module sc_ones_counter #(
    parameter int CW  = 8,
    parameter int CYW = 7,
    parameter int LEN = 127
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          x,
    output logic [CW-1:0] count_next,
    output logic          tc
);
    logic [CW-1:0]  ones_cnt;
    logic [CYW-1:0] cyc_cnt;

    // count_next already includes the current sample so the final cycle is not lost
    assign count_next = ones_cnt + CW'(x);
    assign tc         = (cyc_cnt == CYW'(LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (clr) begin
            ones_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (en) begin
            ones_cnt <= count_next;
            cyc_cnt  <= cyc_cnt + CYW'(1);
        end
    end
endmodule

// File: rtl/sc_stream_decoder.sv
// Sequences an LFSR stochastic generator over one window and reports the ones count.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_LOAD | generator loads captured seed
//   ST_RUN  | generator enabled, LEN samples accumulated
//   ST_DONE | result presented until result_ready
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LEN = 2**N - 1,
    parameter int CW  = N + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] seed_in,
    input  logic         clear,
    output logic         busy,
    sc_stream_decoder_if.master bus
);
    localparam int CYW = clog2(LEN + 1);

    state_t        state;
    logic [N-1:0]  seed_q;
    logic [CW-1:0] result_q;
    logic          valid_q;
    logic          load_q;
    logic          enable_q;
    logic [CW-1:0] count_next;
    logic          tc;

    sc_ones_counter #(
        .CW  (CW),
        .CYW (CYW),
        .LEN (LEN)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clear || (state == ST_LOAD)),
        .en         (state == ST_RUN),
        .x          (bus.x_in),
        .count_next (count_next),
        .tc         (tc)
    );

    // Outputs are updated together with the state so they always match the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            seed_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            busy     <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            valid_q  <= 1'b0;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_q <= seed_in;
                        state  <= ST_LOAD;
                        load_q <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_RUN;
                    load_q   <= 1'b0;
                    enable_q <= 1'b1;
                end
                ST_RUN: begin
                    if (tc) begin
                        result_q <= count_next;
                        valid_q  <= 1'b1;
                        enable_q <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    valid_q  <= 1'b0;
                    load_q   <= 1'b0;
                    enable_q <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_load     = load_q;
    assign bus.gen_enable   = enable_q;
    assign bus.gen_seed     = seed_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench: decoder wired to a 7-bit maximal LFSR comparator generator.
module tb_sc_stream_decoder;
    localparam int N  = 7;
    localparam int CW = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         clear;
    logic [N-1:0] seed_in;
    logic         busy;

    int vec_cnt;
    int err_cnt;
    int k_val;
    int load_cnt;
    int en_cnt;
    int both_cnt;
    logic [N-1:0] lfsr;

    sc_stream_decoder_if #(.N(N), .CW(CW)) bus ();

    sc_stream_decoder #(.N(N), .LEN(127), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .seed_in (seed_in),
        .clear   (clear),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // x^7 + x^6 + 1 maximal LFSR, all-zero seed replaced by all-ones
    always @(posedge clk) begin
        if (bus.gen_load)
            lfsr <= (bus.gen_seed == '0) ? 7'h7F : bus.gen_seed;
        else if (bus.gen_enable)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
    assign bus.x_in = (int'(lfsr) < k_val);

    always @(negedge clk) begin
        if (bus.gen_load) load_cnt++;
        if (bus.gen_enable) en_cnt++;
        if (bus.gen_load && bus.gen_enable) both_cnt++;
    end

    task automatic run_conv(input logic [N-1:0] seed, input int k, input bit inject,
                            output int cyc, output logic [CW-1:0] res);
        k_val = k;
        seed_in = seed;
        start = 1'b1;
        load_cnt = 0;
        en_cnt = 0;
        both_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (bus.result_valid !== 1'b1 && cyc < 400) begin
            if (inject && cyc == 40) begin
                start = 1'b1;
                seed_in = 7'h33;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        res = bus.result;
    endtask

    task automatic test_reset();
        vec_cnt++; if (bus.result !== 8'd0) begin err_cnt++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
        vec_cnt++; if (bus.result_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
        vec_cnt++; if (bus.gen_load !== 1'b0) begin err_cnt++; $display("FAIL reset_gen_load: got %b expected 0", bus.gen_load); end
        vec_cnt++; if (bus.gen_enable !== 1'b0) begin err_cnt++; $display("FAIL reset_gen_enable: got %b expected 0", bus.gen_enable); end
        vec_cnt++; if (bus.gen_seed !== 7'd0) begin err_cnt++; $display("FAIL reset_gen_seed: got %0d expected 0", bus.gen_seed); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int cyc;
        logic [CW-1:0] res;
        bus.result_ready = 1'b1;
        run_conv(7'h01, 64, 1'b0, cyc, res);
        vec_cnt++; if (cyc !== 129) begin err_cnt++; $display("FAIL basic_latency: got %0d expected 129", cyc); end
        vec_cnt++; if (res !== 8'd63) begin err_cnt++; $display("FAIL basic_result: got %0d expected 63", res); end
        vec_cnt++; if (load_cnt !== 1) begin err_cnt++; $display("FAIL basic_load_cycles: got %0d expected 1", load_cnt); end
        vec_cnt++; if (en_cnt !== 127) begin err_cnt++; $display("FAIL basic_enable_cycles: got %0d expected 127", en_cnt); end
        vec_cnt++; if (both_cnt !== 0) begin err_cnt++; $display("FAIL basic_load_and_enable: got %0d expected 0", both_cnt); end
        @(negedge clk);
        vec_cnt++; if (bus.result_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL basic_handshake: valid %b busy %b expected 0 0", bus.result_valid, busy);
        end
    endtask

    task automatic test_boundaries();
        int ks[3] = '{0, 1, 127};
        logic [N-1:0] seeds[3] = '{7'h01, 7'h5A, 7'h00};
        int cyc;
        int exp;
        logic [CW-1:0] res;
        bus.result_ready = 1'b1;
        foreach (ks[i]) begin
            foreach (seeds[j]) begin
                exp = (ks[i] > 0) ? ks[i] - 1 : 0;
                run_conv(seeds[j], ks[i], 1'b0, cyc, res);
                vec_cnt++;
                if (res !== CW'(exp) || cyc !== 129) begin
                    err_cnt++;
                    $display("FAIL boundary k=%0d seed=%h: got %0d after %0d cycles expected %0d after 129", ks[i], seeds[j], res, cyc, exp);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit held;
        logic [CW-1:0] res;
        bus.result_ready = 1'b0;
        run_conv(7'h22, 100, 1'b0, cyc, res);
        vec_cnt++; if (res !== 8'd99) begin err_cnt++; $display("FAIL bp_result: got %0d expected 99", res); end
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b1 || bus.result !== 8'd99 || busy !== 1'b1) held = 1'b0;
        end
        vec_cnt++; if (held !== 1'b1) begin err_cnt++; $display("FAIL bp_hold: got valid %b result %0d expected 1 99", bus.result_valid, bus.result); end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        vec_cnt++; if (bus.result_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL bp_release: valid %b busy %b expected 0 0", bus.result_valid, busy);
        end
        vec_cnt++; if (bus.result !== 8'd99) begin err_cnt++; $display("FAIL bp_result_kept: got %0d expected 99", bus.result); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        logic [CW-1:0] res;
        bus.result_ready = 1'b0;
        run_conv(7'h5A, 64, 1'b1, cyc, res);
        vec_cnt++; if (cyc !== 129 || res !== 8'd63) begin
            err_cnt++; $display("FAIL ign_run: got %0d after %0d cycles expected 63 after 129", res, cyc);
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (bus.result_valid !== 1'b1 || load_cnt !== 1 || bus.gen_seed !== 7'h5A) begin
            err_cnt++; $display("FAIL ign_done: valid %b loads %0d seed %h expected 1 1 5a", bus.result_valid, load_cnt, bus.gen_seed);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0 || load_cnt !== 1) begin
            err_cnt++; $display("FAIL ign_handshake_start: busy %b loads %0d expected 0 1", busy, load_cnt);
        end
    endtask

    task automatic test_clear();
        int cyc;
        int guard;
        bit seen;
        logic [CW-1:0] res;
        logic [CW-1:0] res_before;
        res_before = bus.result;
        bus.result_ready = 1'b1;
        k_val = 64;
        seed_in = 7'h01;
        start = 1'b1;
        en_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (en_cnt < 50 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vec_cnt++; if (bus.gen_enable !== 1'b0 || busy !== 1'b0 || guard >= 200) begin
            err_cnt++; $display("FAIL clear_abort: gen_enable %b busy %b expected 0 0", bus.gen_enable, busy);
        end
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL clear_no_valid: got valid during idle expected none"); end
        vec_cnt++; if (bus.result !== res_before) begin err_cnt++; $display("FAIL clear_result_kept: got %0d expected %0d", bus.result, res_before); end
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        vec_cnt++; if (busy !== 1'b0 || bus.gen_load !== 1'b0) begin
            err_cnt++; $display("FAIL clear_beats_start: busy %b gen_load %b expected 0 0", busy, bus.gen_load);
        end
        run_conv(7'h01, 10, 1'b0, cyc, res);
        vec_cnt++; if (res !== 8'd9) begin err_cnt++; $display("FAIL clear_next_conv: got %0d expected 9", res); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [CW-1:0] res;
        bit held;
        bus.result_ready = 1'b1;
        k_val = 64;
        seed_in = 7'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.gen_enable !== 1'b0 || bus.gen_load !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL arst_ctrl: enable %b load %b busy %b expected 0 0 0", bus.gen_enable, bus.gen_load, busy);
        end
        vec_cnt++; if (bus.result !== 8'd0 || bus.result_valid !== 1'b0 || bus.gen_seed !== 7'd0) begin
            err_cnt++; $display("FAIL arst_data: result %0d valid %b seed %h expected 0 0 0", bus.result, bus.result_valid, bus.gen_seed);
        end
        held = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.gen_enable !== 1'b0 || busy !== 1'b0 || bus.result_valid !== 1'b0) held = 1'b0;
        end
        rst_n = 1'b1;
        vec_cnt++; if (held !== 1'b1) begin err_cnt++; $display("FAIL arst_hold: outputs left reset values while rst_n low"); end
        @(negedge clk);
        run_conv(7'h01, 64, 1'b0, cyc, res);
        vec_cnt++; if (res !== 8'd63 || cyc !== 129) begin
            err_cnt++; $display("FAIL arst_recover: got %0d after %0d cycles expected 63 after 129", res, cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        seed_in = '0;
        bus.result_ready = 1'b0;
        lfsr = 7'h7F;
        k_val = 0;
        vec_cnt = 0;
        err_cnt = 0;
        load_cnt = 0;
        en_cnt = 0;
        both_cnt = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_boundaries();
        test_backpressure();
        test_start_ignored();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
